// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared core definitions used by the fetch stage and the branch unit.
//   XLEN          : datapath / PC width
//   pc_src_e      : next-PC select encoding (2'b11 is reserved, acts as PC_SEQ)
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0)
//   word_misaligned(): alignment check on the two low address bits
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_REL  = 2'b01,
        PC_JALR = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_VALID = 2'b10,
        S_TRAP  = 2'b11
    } fetch_state_e;

    // A fetch target is legal only when it lands on a 4-byte boundary.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : fetch complete, imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_pc_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC selection, shared with the branch unit.
//   pc         in  : current PC
//   pc_src     in  : 00 PC+4, 01 PC+imm_ext, 10 JALR, 11 treated as PC+4
//   imm_ext    in  : sign-extended immediate
//   alu_result in  : JALR base+offset sum (bit 0 is cleared)
//   next_pc    out : selected target
//   pc_plus4   out : pc + 4 (wraps modulo 2^XLEN)
//   misaligned out : target not 4-byte aligned
// Macro FETCH_MISALIGN_TRAP_EN: when defined, misaligned targets are passed
// through and flagged; otherwise the low two bits are forced to zero and the
// flag is never raised.
// ---------------------------------------------------------------------------
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] FOUR_C      = XLEN'(32'd4);
    localparam logic [XLEN-1:0] JALR_MASK_C = ~XLEN'(32'd1);
    localparam logic [XLEN-1:0] WORD_MASK_C = ~XLEN'(32'd3);

    logic [XLEN-1:0] target_s;

    assign pc_plus4 = pc + FOUR_C;

    // Target mux; the reserved encoding falls through to sequential.
    always_comb begin
        target_s = pc_plus4;
        case (pc_src)
            PC_SEQ:  target_s = pc_plus4;
            PC_REL:  target_s = pc + imm_ext;
            PC_JALR: target_s = alu_result & JALR_MASK_C;
            default: target_s = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc    = target_s;
    assign misaligned = word_misaligned(target_s[1:0]);
`else
    assign next_pc    = target_s & WORD_MASK_C;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
// PC register and instruction-fetch stage. Fetches one word per instruction
// over the imem bus, presents it to decode, and on retirement moves the PC to
// the sequential, branch/JAL or JALR target. A flush redirects the PC; a flush
// that arrives mid-request is remembered and applied when the outstanding
// request completes (its data is discarded).
// Ports:
//   clk, rst_n             : core clock, asynchronous active-low reset
//   imem (master)          : imem_req/imem_addr out, imem_ack/imem_rdata in
//   instr, instr_valid     : fetched instruction and its valid flag
//   instr_ready            : retire strobe; pc_src/imm_ext/alu_result valid
//   pc_src, imm_ext, alu_result : next-PC selection inputs
//   flush, flush_pc        : redirect request and target
//   pc, pc_plus4           : PC of instr and PC+4
//   misalign_trap, misalign_addr : misaligned target flag and address
// Macro FETCH_MISALIGN_TRAP_EN: enables the misaligned-target trap (S_TRAP);
// when undefined targets are word-aligned and the trap outputs stay 0.
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_pc_unit_if.master     imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic [1:0]          pc_src,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                flush,
    input  logic [XLEN-1:0]     flush_pc,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                misalign_trap,
    output logic [XLEN-1:0]     misalign_addr
);
    import riscv_pkg::*;

    fetch_state_e    state_r, state_n;
    logic [XLEN-1:0] pc_r, pc_n;
    logic [31:0]     instr_r, instr_n;
    logic            req_r, req_n;
    logic            valid_r, valid_n;
    logic            trap_r, trap_n;
    logic [XLEN-1:0] maddr_r, maddr_n;
    logic            pend_r, pend_n;
    logic [XLEN-1:0] pend_pc_r, pend_pc_n;

    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc         (pc_r),
        .pc_src     (pc_src),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (next_pc_s),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned_s)
    );

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_n   = state_r;
        pc_n      = pc_r;
        instr_n   = instr_r;
        trap_n    = trap_r;
        maddr_n   = maddr_r;
        pend_n    = pend_r;
        pend_pc_n = pend_pc_r;

        case (state_r)
            S_IDLE: begin
                if (flush) begin
                    pc_n   = flush_pc;
                    trap_n = 1'b0;
                end else begin
                    pc_n = pc_r;
                end
                state_n = S_REQ;
            end

            S_REQ: begin
                if (imem.imem_ack) begin
                    if (flush) begin
                        // Fresh redirect wins over any older pending target.
                        pc_n   = flush_pc;
                        pend_n = 1'b0;
                    end else if (pend_r) begin
                        pc_n   = pend_pc_r;
                        pend_n = 1'b0;
                    end else begin
                        instr_n = imem.imem_rdata;
                        state_n = S_VALID;
                    end
                end else begin
                    // Request stays on the bus; remember where to go next.
                    if (flush) begin
                        pend_n    = 1'b1;
                        pend_pc_n = flush_pc;
                    end else begin
                        pend_n = pend_r;
                    end
                end
            end

            S_VALID: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    trap_n  = 1'b0;
                    state_n = S_REQ;
                end else if (instr_ready) begin
                    pc_n = next_pc_s;
                    if (misaligned_s) begin
                        trap_n  = 1'b1;
                        maddr_n = next_pc_s;
                        state_n = S_TRAP;
                    end else begin
                        state_n = S_REQ;
                    end
                end else begin
                    state_n = S_VALID;
                end
            end

            S_TRAP: begin
                if (flush) begin
                    pc_n    = flush_pc;
                    trap_n  = 1'b0;
                    state_n = S_REQ;
                end else begin
                    state_n = S_TRAP;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the state being entered.
        req_n   = (state_n == S_REQ);
        valid_n = (state_n == S_VALID);
    end

    // State, PC and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            instr_r   <= NOP_INSTR;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            trap_r    <= 1'b0;
            maddr_r   <= {XLEN{1'b0}};
            pend_r    <= 1'b0;
            pend_pc_r <= {XLEN{1'b0}};
        end else begin
            state_r   <= state_n;
            pc_r      <= pc_n;
            instr_r   <= instr_n;
            req_r     <= req_n;
            valid_r   <= valid_n;
            trap_r    <= trap_n;
            maddr_r   <= maddr_n;
            pend_r    <= pend_n;
            pend_pc_r <= pend_pc_n;
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign instr_valid    = valid_r;
    assign pc             = pc_r;
    assign misalign_trap  = trap_r;
    assign misalign_addr  = maddr_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
// Directed test of fetch_pc_unit with RESET_PC = 32'h100. Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_trap;
    logic [31:0] misalign_addr;

    int n_checks;
    int n_fail;

    fetch_pc_unit_if imem_bus ();

    fetch_pc_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_src        (pc_src),
        .imm_ext       (imm_ext),
        .alu_result    (alu_result),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misalign_trap (misalign_trap),
        .misalign_addr (misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Acknowledge the pending request with word d; instruction must appear next cycle.
    task automatic fetch(input string tag, input logic [31:0] d);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = d;
        @(negedge clk);
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0000_0000;
        check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check_eq({tag, "_instr"}, instr, d);
        check_eq({tag, "_req_lo"}, {31'd0, imem_bus.imem_req}, 32'd0);
    endtask

    // Retire the current instruction with the given next-PC inputs.
    task automatic retire(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        instr_ready = 1'b1;
        pc_src      = src;
        imm_ext     = imm;
        alu_result  = alu;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src      = 2'b00;
        imm_ext     = 32'h0000_0000;
        alu_result  = 32'h0000_0000;
    endtask

    // Request on the bus at address a, no instruction presented.
    task automatic expect_req(input string tag, input logic [31:0] a);
        check_eq({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
        check_eq({tag, "_addr"}, imem_bus.imem_addr, a);
        check_eq({tag, "_novalid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        rst_n               = 1'b0;
        instr_ready         = 1'b0;
        pc_src              = 2'b00;
        imm_ext             = 32'h0000_0000;
        alu_result          = 32'h0000_0000;
        flush               = 1'b0;
        flush_pc            = 32'h0000_0000;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check_eq("rst_pc", pc, 32'h0000_0100);
        check_eq("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_trap", {31'd0, misalign_trap}, 32'd0);
        check_eq("rst_maddr", misalign_addr, 32'h0000_0000);

        rst_n = 1'b1;
        for (int i = 0; i < 8 && !imem_bus.imem_req; i++) @(negedge clk);
        expect_req("first", 32'h0000_0100);
        fetch("first", 32'h00A0_0093);
        check_eq("first_pc", pc, 32'h0000_0100);
        check_eq("first_pc4", pc_plus4, 32'h0000_0104);

        // JALR to 0x201 lands on 0x200 (bit 0 cleared, still word aligned).
        retire(2'b10, 32'h0000_0000, 32'h0000_0201);
        expect_req("jalr200", 32'h0000_0200);
        fetch("f200", 32'h1111_1111);

        // Backward branch: 0x200 + (-16).
        retire(2'b01, 32'hFFFF_FFF0, 32'h0000_0000);
        expect_req("br_back", 32'h0000_01F0);
        fetch("f1f0", 32'h2222_2222);

        retire(2'b10, 32'h0000_0000, 32'h0000_0305);
        expect_req("jalr304", 32'h0000_0304);
        fetch("f304", 32'h3333_3333);

        retire(2'b10, 32'h0000_0000, 32'h0000_0201);
        expect_req("back200", 32'h0000_0200);
        fetch("f200b", 32'h4444_4444);

        // Branch to 0x206: trap when enabled, otherwise word-aligned to 0x204.
        retire(2'b01, 32'h0000_0006, 32'h0000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_trap", {31'd0, misalign_trap}, 32'd1);
        check_eq("mis_addr", misalign_addr, 32'h0000_0206);
        check_eq("mis_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_eq("mis_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("mis_hold", {31'd0, misalign_trap}, 32'd1);
`else
        expect_req("noalign", 32'h0000_0204);
        check_eq("noalign_trap", {31'd0, misalign_trap}, 32'd0);
        check_eq("noalign_maddr", misalign_addr, 32'h0000_0000);
        fetch("f204", 32'h5555_5555);
`endif
        flush    = 1'b1;
        flush_pc = 32'h0000_0400;
        @(negedge clk);
        flush    = 1'b0;
        expect_req("flush400", 32'h0000_0400);
        check_eq("flush400_trap", {31'd0, misalign_trap}, 32'd0);

        // Flush while the request is outstanding: ack arrives 3 cycles later.
        flush    = 1'b1;
        flush_pc = 32'h0000_0800;
        @(negedge clk);
        flush    = 1'b0;
        flush_pc = 32'h0000_0000;
        expect_req("pend_hold", 32'h0000_0400);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_req("pend_wait", 32'h0000_0400);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_ack   = 1'b0;
        expect_req("pend_redir", 32'h0000_0800);
        fetch("f800", 32'h0010_0093);

        // Wrap-around of PC+4.
        retire(2'b10, 32'h0000_0000, 32'hFFFF_FFFD);
        expect_req("top", 32'hFFFF_FFFC);
        fetch("ftop", 32'h6666_6666);
        check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
        retire(2'b00, 32'h0000_0000, 32'h0000_0000);
        expect_req("wrap", 32'h0000_0000);
        fetch("f0", 32'h7777_7777);

        // Flush beats a simultaneous retire.
        flush    = 1'b1;
        flush_pc = 32'h0000_0C00;
        retire(2'b01, 32'h0000_0040, 32'h0000_0000);
        flush    = 1'b0;
        expect_req("flush_wins", 32'h0000_0C00);

        // Flush together with ack: data dropped, redirect immediately.
        flush               = 1'b1;
        flush_pc            = 32'h0000_0900;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        flush               = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        expect_req("flush_ack", 32'h0000_0900);
        fetch("f900", 32'h8888_8888);

        // Reserved pc_src behaves as sequential.
        retire(2'b11, 32'h0000_0100, 32'h0000_0500);
        expect_req("rsvd", 32'h0000_0904);

        // Asynchronous reset while the request is up.
        rst_n = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_eq("arst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("arst_trap", {31'd0, misalign_trap}, 32'd0);
        check_eq("arst_pc", pc, 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the RISC-V core. It owns the PC register, issues word fetches to instruction memory over a request/acknowledge handshake, and presents each fetched instruction to the decoder and immediate extender. It consumes the extended immediate (`imm_ext`) and the ALU result to compute branch, JAL and JALR targets once the current instruction retires.

## Interface
- `XLEN`, 32: datapath and PC width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request; held high until `imem_ack`.
- `imem_addr` out XLEN: fetch address; stable while `imem_req` is high.
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: instruction to the decoder and extender (bits [31:7] feed the extender).
- `instr_valid` out 1: `instr`, `pc` and `pc_plus4` are valid.
- `instr_ready` in 1: the core retires the instruction this cycle; `pc_src`, `imm_ext` and `alu_result` are valid.
- `pc_src` in 2: next-PC select. 00 = PC+4, 01 = PC+`imm_ext` (branch taken or JAL), 10 = JALR, 11 = reserved (treated as 00).
- `imm_ext` in XLEN: sign-extended immediate from the extender.
- `alu_result` in XLEN: JALR base+offset sum.
- `flush` in 1: redirect request, e.g. trap vector or debug.
- `flush_pc` in XLEN: redirect target.
- `pc` out XLEN: PC of `instr`.
- `pc_plus4` out XLEN: `pc`+4, used for the JAL/JALR rd write.
- `misalign_trap` out 1: the computed target was not 4-byte aligned.
- `misalign_addr` out XLEN: the offending target.

## Operation
- FSM states: `S_IDLE`, `S_REQ`, `S_VALID`, `S_TRAP`.
- Reset values: `pc`=`RESET_PC`; state=`S_IDLE`; `imem_req`=0; `instr_valid`=0; `instr`=32'h0000_0013 (NOP); `misalign_trap`=0; `misalign_addr`=0; flush-pending flag=0.
- `S_IDLE` → `S_REQ` unconditionally on the first clock edge after reset release.
- `S_REQ`:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: register `imem_rdata` into `instr`, then go to `S_VALID`.
- `S_VALID`:
  - `instr_valid`=1 and `instr` is held.
  - On `instr_ready`: `pc` ← `next_pc`.
  - If `next_pc[1:0]`≠0: go to `S_TRAP`, set `misalign_trap`=1, set `misalign_addr`=`next_pc`.
  - Otherwise go to `S_REQ`.
- `S_TRAP`: `imem_req`=0 and `instr_valid`=0. The unit stays here until `flush`.
- `next_pc` computation:
  - 00 → `pc`+4.
  - 01 → `pc`+`imm_ext`.
  - 10 → `alu_result` & ~1.
  - All additions are modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- `flush` behaviour:
  - In `S_IDLE`, `S_VALID` or `S_TRAP`: `pc` ← `flush_pc`, clear `misalign_trap`, go to `S_REQ`. `flush` takes priority over a simultaneous `instr_ready`; that instruction is dropped.
  - In `S_REQ` without `imem_ack`: the request is not withdrawn. Latch `flush_pc` and set flush-pending.
  - On the next `imem_ack`: discard the data, load `pc` from the latched target, clear pending, stay in `S_REQ`.
  - In `S_REQ` with `imem_ack` in the same cycle: discard the data and redirect immediately.
  - A later `flush` while pending overwrites the latched target.
- Reset asserted mid-transaction aborts immediately: `imem_req` drops asynchronously.

## Timing
- `imem_req` is registered: it rises the cycle after entering `S_REQ`.
- Minimum fetch latency is 2 cycles per instruction: an ack in the first `S_REQ` cycle gives `instr_valid` in the next cycle.
- Zero-wait throughput is one instruction per 2 cycles.
- `instr_ready` at edge N → `imem_addr`=new PC and `imem_req`=1 from cycle N+1.
- `next_pc` is combinational from `pc_src`/`imm_ext`/`alu_result`; it is sampled only when `instr_valid` && `instr_ready`.
- `pc_plus4` is combinational from `pc`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: behaviour as above; misaligned targets enter `S_TRAP`.
- Not defined:
  - `next_pc[1:0]` is forced to 00 and no trap is raised.
  - `S_TRAP` is unreachable; `misalign_trap` and `misalign_addr` are tied to 0.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`;
  - the `pc_src_e` enum (`PC_SEQ`, `PC_REL`, `PC_JALR`);
  - the `fetch_state_e` FSM typedef;
  - the `NOP_INSTR` constant.
- One sub-module, `pc_next_sel`: purely combinational `next_pc` mux, adders and alignment check, reused by the branch unit.
- The FSM, PC register and flush-pending logic stay in `fetch_pc_unit`.

## Test plan
- Reset with `RESET_PC`=32'h100 and ack on the first request → `imem_addr`=32'h100; `instr_valid` in the cycle after ack; `instr` equals `imem_rdata`.
- `pc`=32'h200, `pc_src`=01, `imm_ext`=32'hFFFF_FFF0, `instr_ready` → next `imem_addr`=32'h1F0.
- JALR with `alu_result`=32'h0000_0305 → target 32'h304. With the macro defined, `imm_ext`=6 (target 0x206) → `misalign_trap`=1 and `misalign_addr`=32'h206.
- `flush` (`flush_pc`=32'h800) in `S_REQ`, ack 3 cycles later → data discarded, then `imem_addr`=32'h800 with no `instr_valid` between.
- `pc`=32'hFFFF_FFFC, `pc_src`=00 → next `imem_addr`=0. Simultaneous `flush` and `instr_ready` → `flush_pc` wins.
- `rst_n` low while `imem_req`=1 → `imem_req`, `instr_valid` and `misalign_trap` go to 0 immediately and `pc`=`RESET_PC`.
